nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
Sequencer that computes a WORD_W-bit sum using one shared 4-bit ripple-carry adder, one nibble per clock cycle, least-significant nibble first.
- Accepts operands over a valid/ready handshake.
- Keeps the inter-nibble carry in a register.
- Presents the full result over a valid/ready handshake.
- Sits between an operand source (register file or test stimulus) and any result consumer; it is the controller around the team's 4-bit adder datapath.

Parameters:
- WORD_W, 16, operand and result width in bits. Must be a multiple of 4 and at least 8.
- NIB_CNT, WORD_W/4, number of nibble steps. Derived; not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  controller can accept operands.
- in_x  input  WORD_W  operand X.
- in_y  input  WORD_W  operand Y.
- in_cin  input  1  carry-in into nibble 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WORD_W  X+Y+cin, modulo 2^WORD_W.
- out_cout  output  1  carry out of the MSB nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - out_sum=0, out_cout=0, carry register=0, nibble index=0.
  - Operand registers are cleared to 0.
- States IDLE, RUN, DONE. Transitions:
  - IDLE -> RUN on in_valid&&in_ready. That edge captures in_x, in_y, in_cin; index set to 0; carry register set to in_cin.
  - RUN: each cycle the adder receives X[4i+3:4i], Y[4i+3:4i] and the carry register.
    - Its 4-bit sum is written to out_sum[4i+3:4i].
    - Its carry-out is written to the carry register.
    - i increments by 1.
  - RUN -> DONE on the edge that processes i=NIB_CNT-1. That edge also loads out_cout with the final carry.
  - DONE -> IDLE on out_valid&&out_ready.
- Output timing:
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
  - busy=1 in RUN and DONE.
  - out_sum and out_cout are stable for the whole time out_valid is high.
- Latency: with the accept edge as cycle 0, out_valid rises after NIB_CNT further edges (cycle 4 for WORD_W=16). Best-case throughput is one operation per NIB_CNT+2 cycles.
- Boundary conditions:
  - in_valid during RUN or DONE is ignored and operands are not sampled. The source must hold them, per valid/ready rules.
  - Holding out_ready low keeps DONE indefinitely with outputs frozen.
  - out_ready high on the cycle DONE is entered gives a one-cycle out_valid pulse. The next accept occurs no earlier than the following cycle; there is no IDLE bypass.
  - Wrap-around: the sum is truncated to WORD_W bits and overflow appears only on out_cout. The index counter never exceeds NIB_CNT-1.
  - Reset asserted mid-RUN or mid-DONE aborts immediately to reset values, and any partial sum is discarded.
  - out_sum bits of nibbles not yet processed hold their previous values during RUN. They are not valid until DONE.

Optional Feature:
- Macro NIBBLE_ADD_SUB_EN.
- When defined:
  - Adds input port in_sub (1 bit), sampled together with the operands at accept.
  - in_sub=1: Y is inverted nibble-wise before the adder, the initial carry is forced to 1 and in_cin is ignored. out_sum = X-Y mod 2^WORD_W; out_cout=1 means no borrow.
  - in_sub=0: same as addition.
- When undefined: no in_sub port; addition only.

Decomposition:
- Package nibble_add_pkg holds:
  - NIB_W=4 constant.
  - State enum type (IDLE, RUN, DONE) with a 2-bit encoding.
  - A function computing the index counter width, ceil(log2(NIB_CNT)).
- One sub-module, nibble_adder4: combinational 4-bit ripple-carry adder with ports a[3:0], b[3:0], ci, s[3:0], co. It is instantiated once, and the controller owns all state.

Test Plan:
- Basic add: WORD_W=16, X=0x1234, Y=0x4321, cin=0 -> out_sum=0x5555, out_cout=0, out_valid rises 4 edges after accept.
- Full carry ripple: X=0xFFFF, Y=0x0001, cin=0 -> out_sum=0x0000, out_cout=1. Also X=0xFFFF, Y=0x0000, cin=1 -> out_sum=0x0000, out_cout=1.
- Backpressure: out_ready low for 10 cycles after DONE -> out_valid stays 1, out_sum constant, in_ready stays 0, and a new in_valid is not accepted until the cycle after the handshake.
- Ignored input: drive in_valid with X=0xAAAA during RUN of 0x0101+0x0202 -> result 0x0303, and 0xAAAA is never sampled.
- Reset mid-RUN: assert rst_n=0 after 2 nibble cycles -> all outputs return to reset values asynchronously; after release, a fresh 0x0F0F+0x00F1 yields 0x1000.
- With NIBBLE_ADD_SUB_EN: X=0x0005, Y=0x0007, in_sub=1 -> out_sum=0xFFFE, out_cout=0. X=0x0007, Y=0x0005 -> out_sum=0x0002, out_cout=1.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// Shared constants and types for the nibble-serial adder controller.
package nibble_add_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ceil(log2(nib_cnt)), never below 1 so the index register always exists
  function automatic int unsigned idx_width(input int unsigned nib_cnt);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < nib_cnt) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/nibble_adder4.sv
// Combinational 4-bit ripple-carry adder shared by every nibble step.
module nibble_adder4
  import nibble_add_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic [NIB_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < NIB_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer computing a WORD_W-bit sum one nibble per cycle, LSB nibble first.
// Optional subtraction mode enabled by defining NIBBLE_ADD_SUB_EN.
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_x,
  input  logic [WORD_W-1:0] in_y,
  input  logic              in_cin,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic              in_sub,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_cout,
  output logic              busy
);

  localparam int unsigned    NIB_CNT  = WORD_W / NIB_W;
  localparam int unsigned    IDX_W    = idx_width(NIB_CNT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB_CNT - 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] x_q, x_d;
  logic [WORD_W-1:0] y_q, y_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [WORD_W-1:0] y_load;
  logic              cin_load;
  int unsigned       nib_base;
  logic [NIB_W-1:0]  add_s;
  logic              add_co;

  // Subtraction is folded in at capture: store ~Y and force the first carry.
`ifdef NIBBLE_ADD_SUB_EN
  assign y_load   = in_sub ? ~in_y : in_y;
  assign cin_load = in_sub | in_cin;
`else
  assign y_load   = in_y;
  assign cin_load = in_cin;
`endif

  assign nib_base = 32'(idx_q) * NIB_W;

  nibble_adder4 u_adder (
    .a  (x_q[nib_base +: NIB_W]),
    .b  (y_q[nib_base +: NIB_W]),
    .ci (carry_q),
    .s  (add_s),
    .co (add_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, datapath updates and flag decode from the next state.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d     = in_x;
          y_d     = y_load;
          carry_d = cin_load;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[nib_base +: NIB_W] = add_s;
        carry_d = add_co;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          cout_d  = add_co;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_RUN) || (state_d == ST_DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (table vectors + scoreboard queue).
module tb_nibble_serial_add_ctrl;

  localparam int unsigned WORD_W = 16;
  localparam int          LAT    = 4;

  typedef struct {
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
    logic              cin;
    logic              sub;
    logic [WORD_W-1:0] sum;
    logic              cout;
  } vec_t;

  typedef struct {
    logic [WORD_W-1:0] sum;
    logic              cout;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_x;
  logic [WORD_W-1:0] in_y;
  logic              in_cin;
`ifdef NIBBLE_ADD_SUB_EN
  logic              in_sub;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_sum;
  logic              out_cout;
  logic              busy;

  int   total  = 0;
  int   passed = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WORD_W(WORD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_cin    (in_cin),
`ifdef NIBBLE_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_sum"}, 32'(out_sum), 32'd0);
    chk({nm, "_cout"}, 32'(out_cout), 32'd0);
  endtask

  // Reference model: plain wide add, with Y inverted and carry forced when subtracting.
  function automatic exp_t model(input vec_t v);
    logic [WORD_W:0]   r;
    logic [WORD_W-1:0] yy;
    logic              c;
    exp_t              e;
    yy = v.sub ? ~v.y : v.y;
    c  = v.sub ? 1'b1 : v.cin;
    r  = (WORD_W+1)'(v.x) + (WORD_W+1)'(yy) + (WORD_W+1)'(c);
    e.sum  = r[WORD_W-1:0];
    e.cout = r[WORD_W];
    return e;
  endfunction

  // Returns at the negedge right after the accepting edge.
  task automatic send(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    in_x     = v.x;
    in_y     = v.y;
    in_cin   = v.cin;
`ifdef NIBBLE_ADD_SUB_EN
    in_sub   = v.sub;
`endif
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk({nm, "_accept_timeout"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int n0, input string nm);
    int   n;
    exp_t e;
    n = n0;
    if (n0 == 0) begin
      chk({nm, "_busy_run"}, 32'(busy), 32'd1);
      chk({nm, "_in_ready_run"}, 32'(in_ready), 32'd0);
    end
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(LAT));
    if (exp_q.size() == 0) begin
      chk({nm, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_sum"}, 32'(out_sum), 32'(e.sum));
      chk({nm, "_cout"}, 32'(out_cout), 32'(e.cout));
    end
    if (out_ready) begin
      @(negedge clk);
      chk({nm, "_valid_pulse"}, 32'(out_valid), 32'd0);
      chk({nm, "_idle_ready"}, 32'(in_ready), 32'd1);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    e.sum  = v.sum;
    e.cout = v.cout;
    send(v, nm);
    exp_q.push_back(e);
    wait_result(0, nm);
  endtask

  initial begin
    vec_t v;
    exp_t e;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_cin    = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
    in_sub    = 1'b0;
`endif
    out_ready = 1'b1;

    // Directed vectors: {x, y, cin, sub, sum, cout}
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8001, 1'b0});
    vecs.push_back('{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
`ifdef NIBBLE_ADD_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0});
`endif
    for (int i = 0; i < 6; i++) begin
      v.x   = WORD_W'($urandom);
      v.y   = WORD_W'($urandom);
      v.cin = 1'($urandom_range(0, 1));
`ifdef NIBBLE_ADD_SUB_EN
      v.sub = 1'($urandom_range(0, 1));
`else
      v.sub = 1'b0;
`endif
      e      = model(v);
      v.sum  = e.sum;
      v.cout = e.cout;
      vecs.push_back(v);
    end

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // In_valid with different operands during RUN must not be sampled.
    v = '{16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0};
    send(v, "ign");
    e.sum = 16'h0303; e.cout = 1'b0;
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_x     = 16'hAAAA;
    in_y     = 16'hAAAA;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(2, "ign");
    repeat (3) @(negedge clk);
    chk("ign_not_accepted_busy", 32'(busy), 32'd0);
    chk("ign_not_accepted_ready", 32'(in_ready), 32'd1);

    // Backpressure: DONE held with frozen outputs, new operands wait for the handshake.
    out_ready = 1'b0;
    v = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0};
    run_vec(v, "bp");
    in_valid = 1'b1;
    in_x     = 16'h0001;
    in_y     = 16'h0001;
    in_cin   = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
    in_sub   = 1'b0;
`endif
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_sum", i), 32'(out_sum), 32'h3333);
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("bp_next_accept", 32'(busy), 32'd1);
    in_valid = 1'b0;
    e.sum = 16'h0002; e.cout = 1'b0;
    exp_q.push_back(e);
    wait_result(0, "bp_next");

    // Reset after two nibble steps discards the partial sum.
    v = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0};
    send(v, "rst_run");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_run");
    @(negedge clk);
    rst_n = 1'b1;
    v = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0};
    run_vec(v, "post_rst");

    // Reset while holding a result in DONE.
    out_ready = 1'b0;
    v = '{16'hFFF0, 16'h0020, 1'b0, 1'b0, 16'h0010, 1'b1};
    run_vec(v, "rst_done");
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_done");
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    v = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0};
    run_vec(v, "post_rst2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
